regbank_wb_arbiter: RTL and testbench
=====================================

# regbank_wb_arbiter

Shares the register bank's single write port between two writeback requesters, the ALU and the load/store unit. Round-robin arbitration feeds one registered write stage that drives the bank's write enable, address, data and bank-select inputs. An optional scoreboard tracks registers with an outstanding write. The issue stage uses it to stall reads of stale values. The block sits between the execute/memory stages and the register bank.

## Interface
- WIDTH, 32, data width
- REG_SEL, 5, register address width
- NUM_REGS, 32, scalar registers
- NUM_PRED_REGS, 8, predicate registers
- PRED_REG_SEL, 3, predicate address width (low bits of any address)

Ports:
- Clock and reset (already decided): reset reset, synchronous, active-high; clock clk.
- clk  in  1  clock
- reset  in  1  reset
- alu_valid / lsu_valid  in  1  write request
- alu_ready / lsu_ready  out  1  request accepted this cycle
- alu_addr / lsu_addr  in  REG_SEL  destination register
- alu_sel / lsu_sel  in  1  bank select: 0 scalar, 1 predicate
- alu_data / lsu_data  in  WIDTH  write data
- rf_write_enable  out  1  to bank write_enable
- rf_addr_z  out  REG_SEL  to bank addr_z
- rf_data_z  out  WIDTH  to bank data_z
- rf_z_regbank_sel  out  1  to bank z_regbank_sel
- rsv_valid  in  1  issue stage reserves a destination
- rsv_addr  in  REG_SEL  reserved register
- rsv_sel  in  1  reserved bank
- chk_addr_a, chk_addr_b  in  REG_SEL  source operands to check
- chk_sel_a, chk_sel_b  in  1  source banks
- busy_a, busy_b  out  1  source has a pending write

## Operation
- Priority pointer prio resets to ALU. A one-bit busy vector exists per bank, scalar NUM_REGS and predicate NUM_PRED_REGS.
- Grants are combinational. A requester is granted when its valid is high and either the other requester is idle or prio points to it.
- ready is high only for the granted requester. ready never asserts without valid.
- On each grant, prio moves to the non-granted requester. With no grant, prio holds.
- A request persists while ready is low. Its addr, sel and data stay stable until accepted. The loser of an arbitration round therefore wins the next cycle.
- Accept means valid && ready. On accept, the output stage captures addr, sel and data, and rf_write_enable is 1 the next cycle.
- With no accept, rf_write_enable is 0 the next cycle. The registered rf_addr_z, rf_data_z and rf_z_regbank_sel hold their last values.
- The bank is never back-pressured. At most one write per cycle.
- Predicate writes pass full data; the bank uses bit 0. Predicate index is addr[PRED_REG_SEL-1:0] for reserve, clear and check.
- Same register requested by both sources: serialized by arbitration. The later-granted write wins in the bank.
- Scoreboard (when compiled in):
  - A rsv_valid edge sets busy[rsv_sel][rsv_addr].
  - The edge at the end of an rf_write_enable cycle, when the bank writes, clears busy[rf_z_regbank_sel][rf_addr_z].
  - Set and clear of the same register on the same edge: set wins.
  - Reserving an already-busy register leaves it busy, with no count. WAW avoidance belongs to the issue stage.
  - busy_a = busy[chk_sel_a][chk_addr_a], combinational from state with no bypass. busy_b is the same for the b port.

## Timing
- Reset values: rf_write_enable 0; rf_addr_z, rf_data_z, rf_z_regbank_sel 0; busy bits 0; prio ALU. alu_ready and lsu_ready are 0 during reset cycles.
- Reset mid-operation drops any captured but unwritten write.
- Accept to rf_write_enable high: 1 cycle. Accept to bank contents updated: 2 edges.
- Accept to busy low: 2 cycles after the accept cycle. Busy falls the cycle after rf_write_enable, when a bank read already returns new data.
- Reservation to busy high: 1 cycle.
- Both valid continuously: grants alternate every cycle. Sustained throughput is one write per cycle.

## Configuration
- WB_SCOREBOARD_EN defined: the busy vectors and the reserve, clear and check logic are built.
- Undefined: no scoreboard storage, rsv_* and chk_* ignored, busy_a/busy_b tied 0. Arbitration and write stage are unchanged.

## Structure
- Shared header defines.vh holds WIDTH, REG_SEL, NUM_REGS, NUM_PRED_REGS and PRED_REG_SEL.
- defines.vh also holds requester indices WB_REQ_ALU=0 and WB_REQ_LSU=1, plus the WB_SCOREBOARD_EN default.
- Sub-module wb_scoreboard holds the busy vectors and the set/clear/check ports. It is instantiated only under WB_SCOREBOARD_EN.

## Test plan
- Reset sequencing: after reset, with both valid, ALU wins and lsu_ready=0. Mid-write reset gives rf_write_enable=0 the next cycle and all busy=0.
- Single ALU write: alu_valid, addr 5, sel 0, data 0xDEADBEEF gives alu_ready=1. Next cycle rf_write_enable=1, rf_addr_z=5, rf_data_z=0xDEADBEEF. The cycle after, rf_write_enable=0.
- Contention: both valid for 4 cycles (ALU addr 1, LSU addr 2) gives grants ALU, LSU, ALU, LSU. rf_addr_z sequence 1,2,1,2 with no idle cycle.
- Predicate write: lsu addr 0x0B, sel 1, data 1 gives rf_z_regbank_sel=1 and rf_addr_z=0x0B. Scoreboard predicate index 3 is cleared.
- Scoreboard: reserve r7, chk_addr_a=7 gives busy_a=1 next cycle. ALU writes r7 and busy_a stays 1 through the rf_write_enable cycle, then falls. Reserve and clear of r7 on the same edge leaves busy_a=1.
- Build without WB_SCOREBOARD_EN: reserve r7 gives busy_a=0 always. Write-path waveforms are identical to the scoreboard build.

Source files
------------

// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared parameters and types for the register-bank writeback arbiter.
// Holds the datapath/address widths, bank sizes, requester indices and
// the writeback request payload. The optional scoreboard is enabled by
// defining WB_SCOREBOARD_EN; it is left undefined by default.
package regbank_wb_arbiter_pkg;

    localparam int unsigned WIDTH         = 32;
    localparam int unsigned REG_SEL       = 5;
    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned NUM_PRED_REGS = 8;
    localparam int unsigned PRED_REG_SEL  = 3;

    // Requester indices into the request array
    localparam int unsigned WB_REQ_ALU = 0;
    localparam int unsigned WB_REQ_LSU = 1;
    localparam int unsigned WB_NUM_REQ = 2;

    // Which requester wins the next contended cycle
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSU = 1'b1
    } prio_e;

    // One writeback: bank select, destination and data
    typedef struct packed {
        logic               sel;
        logic [REG_SEL-1:0] addr;
        logic [WIDTH-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for the register bank.
// One busy bit per scalar and per predicate register. A reservation sets
// the bit, the bank write clears it; set wins when both hit the same bit.
// Predicate registers are indexed by the low PRED_REG_SEL address bits.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   set_valid/set_addr/set_sel      reservation from the issue stage
//   clr_valid/clr_addr/clr_sel      write currently presented to the bank
//   chk_addr_a/b, chk_sel_a/b       source operands to look up
//   busy_a/b                        combinational busy lookup (no bypass)
module wb_scoreboard
    import regbank_wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               set_valid,
    input  logic [REG_SEL-1:0] set_addr,
    input  logic               set_sel,
    input  logic               clr_valid,
    input  logic [REG_SEL-1:0] clr_addr,
    input  logic               clr_sel,
    input  logic [REG_SEL-1:0] chk_addr_a,
    input  logic               chk_sel_a,
    input  logic [REG_SEL-1:0] chk_addr_b,
    input  logic               chk_sel_b,
    output logic               busy_a,
    output logic               busy_b
);

    logic [NUM_REGS-1:0]      busy_s_q, busy_s_d;
    logic [NUM_PRED_REGS-1:0] busy_p_q, busy_p_d;

    // Clear first so a same-edge reservation overrides it
    always_comb begin
        busy_s_d = busy_s_q;
        busy_p_d = busy_p_q;
        if (clr_valid) begin
            if (clr_sel) busy_p_d[clr_addr[PRED_REG_SEL-1:0]] = 1'b0;
            else         busy_s_d[clr_addr]                   = 1'b0;
        end
        if (set_valid) begin
            if (set_sel) busy_p_d[set_addr[PRED_REG_SEL-1:0]] = 1'b1;
            else         busy_s_d[set_addr]                   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_s_q <= '0;
            busy_p_q <= '0;
        end else begin
            busy_s_q <= busy_s_d;
            busy_p_q <= busy_p_d;
        end
    end

    assign busy_a = chk_sel_a ? busy_p_q[chk_addr_a[PRED_REG_SEL-1:0]] : busy_s_q[chk_addr_a];
    assign busy_b = chk_sel_b ? busy_p_q[chk_addr_b[PRED_REG_SEL-1:0]] : busy_s_q[chk_addr_b];

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the ALU
// and the load/store unit, followed by one registered write stage.
// Optional pending-write scoreboard built when WB_SCOREBOARD_EN is defined;
// otherwise rsv_*/chk_* are ignored and busy_a/busy_b are tied low.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   alu_*/lsu_*                      writeback requests (valid/ready handshake)
//   rf_write_enable, rf_addr_z,
//   rf_data_z, rf_z_regbank_sel      registered bank write port
//   rsv_valid/rsv_addr/rsv_sel       destination reservation from issue
//   chk_addr_a/b, chk_sel_a/b        source operands to check
//   busy_a, busy_b                   source has a pending write
module regbank_wb_arbiter
    import regbank_wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [REG_SEL-1:0] alu_addr,
    input  logic               alu_sel,
    input  logic [WIDTH-1:0]   alu_data,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [REG_SEL-1:0] lsu_addr,
    input  logic               lsu_sel,
    input  logic [WIDTH-1:0]   lsu_data,
    output logic               rf_write_enable,
    output logic [REG_SEL-1:0] rf_addr_z,
    output logic [WIDTH-1:0]   rf_data_z,
    output logic               rf_z_regbank_sel,
    input  logic               rsv_valid,
    input  logic [REG_SEL-1:0] rsv_addr,
    input  logic               rsv_sel,
    input  logic [REG_SEL-1:0] chk_addr_a,
    input  logic               chk_sel_a,
    input  logic [REG_SEL-1:0] chk_addr_b,
    input  logic               chk_sel_b,
    output logic               busy_a,
    output logic               busy_b
);

    wb_req_t req [WB_NUM_REQ];
    logic    grant_alu, grant_lsu;
    prio_e   prio_q, prio_d;
    logic    we_q, we_d;
    wb_req_t wr_q, wr_d;

    assign req[WB_REQ_ALU] = '{sel: alu_sel, addr: alu_addr, data: alu_data};
    assign req[WB_REQ_LSU] = '{sel: lsu_sel, addr: lsu_addr, data: lsu_data};

    // Grant: sole requester wins, contention goes to prio; nothing in reset
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!reset) begin
            grant_alu = alu_valid && (!lsu_valid || (prio_q == PRIO_ALU));
            grant_lsu = lsu_valid && (!alu_valid || (prio_q == PRIO_LSU));
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    // Next prio and write stage; addr/data/sel hold when nothing is accepted
    always_comb begin
        prio_d = prio_q;
        we_d   = 1'b0;
        wr_d   = wr_q;
        if (grant_alu) begin
            prio_d = PRIO_LSU;
            we_d   = 1'b1;
            wr_d   = req[WB_REQ_ALU];
        end else if (grant_lsu) begin
            prio_d = PRIO_ALU;
            we_d   = 1'b1;
            wr_d   = req[WB_REQ_LSU];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= PRIO_ALU;
            we_q   <= 1'b0;
            wr_q   <= '0;
        end else begin
            prio_q <= prio_d;
            we_q   <= we_d;
            wr_q   <= wr_d;
        end
    end

    assign rf_write_enable  = we_q;
    assign rf_addr_z        = wr_q.addr;
    assign rf_data_z        = wr_q.data;
    assign rf_z_regbank_sel = wr_q.sel;

`ifdef WB_SCOREBOARD_EN
    // The bank write presented this cycle clears its busy bit at the edge
    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_valid  (rsv_valid),
        .set_addr   (rsv_addr),
        .set_sel    (rsv_sel),
        .clr_valid  (we_q),
        .clr_addr   (wr_q.addr),
        .clr_sel    (wr_q.sel),
        .chk_addr_a (chk_addr_a),
        .chk_sel_a  (chk_sel_a),
        .chk_addr_b (chk_addr_b),
        .chk_sel_b  (chk_sel_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );
`else
    logic unused_scoreboard_inputs;
    assign unused_scoreboard_inputs = ^{rsv_valid, rsv_addr, rsv_sel,
                                        chk_addr_a, chk_sel_a, chk_addr_b, chk_sel_b};
    assign busy_a = 1'b0;
    assign busy_b = 1'b0;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: behavioural model plus literal spot checks.
module tb_regbank_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk, reset;
    logic        alu_valid, alu_ready, alu_sel;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready, lsu_sel;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        rf_write_enable, rf_z_regbank_sel;
    logic [4:0]  rf_addr_z;
    logic [31:0] rf_data_z;
    logic        rsv_valid, rsv_sel;
    logic [4:0]  rsv_addr;
    logic [4:0]  chk_addr_a, chk_addr_b;
    logic        chk_sel_a, chk_sel_b;
    logic        busy_a, busy_b;

    regbank_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
        .alu_sel(alu_sel), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
        .lsu_sel(lsu_sel), .lsu_data(lsu_data),
        .rf_write_enable(rf_write_enable), .rf_addr_z(rf_addr_z),
        .rf_data_z(rf_data_z), .rf_z_regbank_sel(rf_z_regbank_sel),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_sel(rsv_sel),
        .chk_addr_a(chk_addr_a), .chk_sel_a(chk_sel_a),
        .chk_addr_b(chk_addr_b), .chk_sel_b(chk_sel_b),
        .busy_a(busy_a), .busy_b(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: who has priority (0 ALU, 1 LSU), pending bank write, busy bits
    bit          m_prio;
    bit          m_we, m_sel;
    bit   [4:0]  m_addr;
    bit   [31:0] m_data;
    bit   [31:0] m_bs;
    bit   [7:0]  m_bp;

    // Last sampled outputs, for literal checks
    logic        s_alu_ready, s_lsu_ready, s_we, s_sel, s_busy_a, s_busy_b;
    logic [4:0]  s_addr;
    logic [31:0] s_data;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit busy_of(input bit [4:0] a, input bit s);
        if (!SB) return 1'b0;
        return s ? m_bp[a[2:0]] : m_bs[a];
    endfunction

    // One clock: check at the falling edge, then advance the model on the rising edge
    task automatic step();
        bit ega, egl;
        @(negedge clk);
        // The sole requester wins; when both ask, the one holding priority wins
        ega = !reset && alu_valid && (!lsu_valid || m_prio == 1'b0);
        egl = !reset && lsu_valid && (!alu_valid || m_prio == 1'b1);
        cmp("alu_ready", 32'(alu_ready), 32'(ega));
        cmp("lsu_ready", 32'(lsu_ready), 32'(egl));
        cmp("rf_write_enable", 32'(rf_write_enable), 32'(m_we));
        cmp("rf_addr_z", 32'(rf_addr_z), 32'(m_addr));
        cmp("rf_data_z", rf_data_z, m_data);
        cmp("rf_z_regbank_sel", 32'(rf_z_regbank_sel), 32'(m_sel));
        cmp("busy_a", 32'(busy_a), 32'(busy_of(chk_addr_a, chk_sel_a)));
        cmp("busy_b", 32'(busy_b), 32'(busy_of(chk_addr_b, chk_sel_b)));
        s_alu_ready = alu_ready; s_lsu_ready = lsu_ready; s_we = rf_write_enable;
        s_addr = rf_addr_z; s_data = rf_data_z; s_sel = rf_z_regbank_sel;
        s_busy_a = busy_a; s_busy_b = busy_b;
        @(posedge clk);
        if (reset) begin
            m_prio = 1'b0; m_we = 1'b0; m_sel = 1'b0; m_addr = '0; m_data = '0;
            m_bs = '0; m_bp = '0;
        end else begin
            if (m_we) begin
                if (m_sel) m_bp[m_addr[2:0]] = 1'b0; else m_bs[m_addr] = 1'b0;
            end
            if (rsv_valid) begin
                if (rsv_sel) m_bp[rsv_addr[2:0]] = 1'b1; else m_bs[rsv_addr] = 1'b1;
            end
            if (ega) begin
                m_we = 1'b1; m_addr = alu_addr; m_data = alu_data; m_sel = alu_sel; m_prio = 1'b1;
            end else if (egl) begin
                m_we = 1'b1; m_addr = lsu_addr; m_data = lsu_data; m_sel = lsu_sel; m_prio = 1'b0;
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
    endtask

    logic [3:0]  g_seq;
    logic [4:0]  a_seq [4];
    logic [3:0]  w_seq;
    logic [15:0] apat, lpat;

    initial begin
        reset = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_sel = 1'b0; alu_data = 32'h3333_0000;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_sel = 1'b0; lsu_data = 32'h4444_0000;
        rsv_valid = 1'b0; rsv_addr = '0; rsv_sel = 1'b0;
        chk_addr_a = 5'd7; chk_sel_a = 1'b0; chk_addr_b = 5'h13; chk_sel_b = 1'b1;
        m_prio = 0; m_we = 0; m_sel = 0; m_addr = 0; m_data = 0; m_bs = 0; m_bp = 0;
        #1;

        // Reset: no ready while reset, all outputs zero
        step(); step();
        cmp("lit_reset_alu_ready", 32'(s_alu_ready), 32'd0);
        cmp("lit_reset_we", 32'(s_we), 32'd0);
        reset = 1'b0;
        step();
        cmp("lit_first_alu_ready", 32'(s_alu_ready), 32'd1);
        cmp("lit_first_lsu_ready", 32'(s_lsu_ready), 32'd0);
        alu_valid = 1'b0;
        step();   // LSU wins its persisted request
        cmp("lit_lsu_after", 32'(s_lsu_ready), 32'd1);
        lsu_valid = 1'b0;
        step(); step();

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 5'd5; alu_sel = 1'b0; alu_data = 32'hDEAD_BEEF;
        step();
        cmp("lit_single_ready", 32'(s_alu_ready), 32'd1);
        alu_valid = 1'b0;
        step();
        cmp("lit_single_we", 32'(s_we), 32'd1);
        cmp("lit_single_addr", 32'(s_addr), 32'd5);
        cmp("lit_single_data", s_data, 32'hDEAD_BEEF);
        step();
        cmp("lit_single_we_off", 32'(s_we), 32'd0);
        cmp("lit_single_addr_hold", 32'(s_addr), 32'd5);

        // Contention from reset: grants alternate, no idle bank cycle
        reset = 1'b1; step(); reset = 1'b0;
        alu_addr = 5'd1; alu_data = 32'h11; lsu_addr = 5'd2; lsu_data = 32'h22; lsu_sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alu_valid = (i < 4); lsu_valid = (i < 4);
            step();
            if (i < 4) g_seq[i] = s_alu_ready;
            if (i > 0) begin a_seq[i-1] = s_addr; w_seq[i-1] = s_we; end
        end
        cmp("lit_cont_grants", 32'(g_seq), 32'b0101);
        cmp("lit_cont_we", 32'(w_seq), 32'b1111);
        for (int i = 0; i < 4; i++) cmp("lit_cont_addr", 32'(a_seq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // Mixed traffic; a requester holds its request until accepted
        apat = 16'b1011_0111_1100_1101; lpat = 16'b0110_1101_1011_0011;
        alu_valid = 1'b0; lsu_valid = 1'b0; s_alu_ready = 1'b0; s_lsu_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!alu_valid || s_alu_ready) begin
                alu_valid = apat[i]; alu_addr = 5'(i); alu_sel = i[0];
                alu_data = 32'hA000_0000 + 32'(i);
            end
            if (!lsu_valid || s_lsu_ready) begin
                lsu_valid = lpat[i]; lsu_addr = 5'(31 - i); lsu_sel = i[1];
                lsu_data = 32'hB000_0000 + 32'(i);
            end
            step();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0; alu_sel = 1'b0; lsu_sel = 1'b0;
        step(); step();
        reset = 1'b1; step(); reset = 1'b0; step();

        // Scoreboard: reserve r7, write r7, busy falls after the write cycle
        chk_addr_a = 5'd7; chk_sel_a = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd7; rsv_sel = 1'b0;
        step();
        rsv_valid = 1'b0;
        step();
        cmp("lit_sb_reserved", 32'(s_busy_a), 32'(SB));
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
        step();
        alu_valid = 1'b0;
        step();
        cmp("lit_sb_during_we", 32'(s_busy_a), 32'(SB));
        cmp("lit_sb_we", 32'(s_we), 32'd1);
        step();
        cmp("lit_sb_cleared", 32'(s_busy_a), 32'd0);
        // Reserve on the same edge as the clearing write: stays busy
        alu_valid = 1'b1;
        step();
        alu_valid = 1'b0; rsv_valid = 1'b1;
        step();
        rsv_valid = 1'b0;
        step();
        cmp("lit_sb_set_wins", 32'(s_busy_a), 32'(SB));

        // Predicate write to 0x0B clears predicate index 3 (checked via 0x13)
        chk_addr_a = 5'h0B; chk_sel_a = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'h0B; rsv_sel = 1'b1;
        step();
        rsv_valid = 1'b0;
        lsu_valid = 1'b1; lsu_addr = 5'h0B; lsu_sel = 1'b1; lsu_data = 32'd1;
        step();
        cmp("lit_pred_ready", 32'(s_lsu_ready), 32'd1);
        lsu_valid = 1'b0;
        step();
        cmp("lit_pred_sel", 32'(s_sel), 32'd1);
        cmp("lit_pred_addr", 32'(s_addr), 32'h0B);
        cmp("lit_pred_busy", 32'(s_busy_b), 32'(SB));
        cmp("lit_pred_scalar_idle", 32'(s_busy_a), 32'd0);
        step();
        cmp("lit_pred_cleared", 32'(s_busy_b), 32'd0);

        // Reset during the write cycle drops the write and all busy bits
        chk_addr_a = 5'd9; chk_sel_a = 1'b0;
        rsv_valid = 1'b1; rsv_addr = 5'd9; rsv_sel = 1'b0;
        step();
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
        step();
        alu_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        cmp("lit_rst_we", 32'(s_we), 32'd0);
        cmp("lit_rst_busy", 32'(s_busy_a), 32'd0);
        cmp("lit_rst_addr", 32'(s_addr), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
